// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I memory/writeback stage: WBSel, funct3 widths, FSM states.
// Captured memory entry is a packed struct so the FSM can hold it as one register.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    WB_MEM  = 2'b00,
    WB_ALU  = 2'b01,
    WB_PC4  = 2'b10,
    WB_ZERO = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            regwen;
    logic            store;
    logic [2:0]      funct3;
  } mem_op_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: misalign check on the incoming entry, store strobes/data and
// load extraction on the captured entry. Zero latency, no flow control.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]      chk_lane,
  input  logic [2:0]      chk_funct3,
  output logic            misaligned,
  input  logic [1:0]      lane,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] st_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    misaligned = 1'b0;
    case (chk_funct3)
      F3_B, F3_BU: misaligned = 1'b0;
      F3_H, F3_HU: misaligned = chk_lane[0];
      default:     misaligned = |chk_lane;
    endcase
  end

  // Unlisted store widths fall through to a full word write.
  always_comb begin
    wstrb = 4'hF;
    wdata = st_data;
    case (funct3)
      F3_B: begin
        wstrb = 4'b0001 << lane;
        wdata = {4{st_data[7:0]}};
      end
      F3_H: begin
        wstrb = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        wstrb = 4'hF;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = rdata[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// RV32I MEM/WB stage: non-memory ops retire 1 cycle after accept; loads/stores run a req/ready + rvalid
// access. stall_out holds upstream while an access is open and drops combinationally on the retiring cycle.
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit WB_X0_GUARD = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] DataB_in,
  input  logic [XLEN-1:0] pcPlus4_in,
  input  logic [4:0]      AddrD_in,
  input  logic            RegWEn_in,
  input  logic            MemRW_in,
  input  logic [1:0]      WBSel_in,
  input  logic [2:0]      funct3_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            RegWEn_out,
  output logic [4:0]      AddrD_out,
  output logic [XLEN-1:0] DataD_out,
  output logic            misalign_err
);

  mem_state_t      state_q, state_d;
  mem_op_t         cap_q, cap_d;
  logic            wb_we_q, wb_we_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            pend_vld_q, pend_vld_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic [XLEN-1:0] pend_data_q, pend_data_d;
  logic            misalign_q, misalign_d;

  logic            in_store, in_load, in_mem, in_misaligned, in_we, cap_we, accept;
  logic [XLEN-1:0] in_wb_data;
  logic [3:0]      lsu_wstrb;
  logic [XLEN-1:0] lsu_wdata, lsu_ld_data;

  lsu_align u_lsu_align (
    .chk_lane   (alu_result_in[1:0]),
    .chk_funct3 (funct3_in),
    .misaligned (in_misaligned),
    .lane       (cap_q.addr[1:0]),
    .funct3     (cap_q.funct3),
    .st_data    (cap_q.wdata),
    .rdata      (dmem_rdata),
    .wstrb      (lsu_wstrb),
    .wdata      (lsu_wdata),
    .ld_data    (lsu_ld_data)
  );

  assign in_store = MemRW_in;
  assign in_load  = !MemRW_in && (WBSel_in == WB_MEM);
  assign in_mem   = in_store || in_load;
  assign in_we    = RegWEn_in && !(WB_X0_GUARD && (AddrD_in == 5'd0));
  assign cap_we   = cap_q.regwen && !(WB_X0_GUARD && (cap_q.rd == 5'd0));

  assign stall_out = ((state_q == REQ) && !(cap_q.store && dmem_ready)) ||
                     ((state_q == WAIT) && !dmem_rvalid);
  assign accept    = valid_in && !stall_out;

  always_comb begin
    in_wb_data = '0;
    case (WBSel_in)
      WB_ALU:  in_wb_data = alu_result_in;
      WB_PC4:  in_wb_data = pcPlus4_in;
      default: in_wb_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    pend_vld_d  = pend_vld_q;
    pend_rd_d   = pend_rd_q;
    pend_data_d = pend_data_q;
    misalign_d  = 1'b0;

    case (state_q)
      REQ: begin
        if (dmem_ready) state_d = cap_q.store ? IDLE : WAIT;
      end
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = IDLE;
          if (cap_we) begin
            wb_we_d   = 1'b1;
            wb_rd_d   = cap_q.rd;
            wb_data_d = lsu_ld_data;
          end
        end
      end
      default: ;
    endcase

    // A non-mem op accepted on the load's retiring edge is parked here and written one cycle later.
    if (pend_vld_q) begin
      wb_we_d    = 1'b1;
      wb_rd_d    = pend_rd_q;
      wb_data_d  = pend_data_q;
      pend_vld_d = 1'b0;
    end

    if (accept) begin
      if (in_mem) begin
        if (in_misaligned) begin
          misalign_d = 1'b1;
        end else begin
          cap_d.addr   = alu_result_in;
          cap_d.wdata  = DataB_in;
          cap_d.rd     = AddrD_in;
          cap_d.regwen = RegWEn_in;
          cap_d.store  = in_store;
          cap_d.funct3 = funct3_in;
          state_d      = REQ;
        end
      end else if (in_we) begin
        if (wb_we_d) begin
          pend_vld_d  = 1'b1;
          pend_rd_d   = AddrD_in;
          pend_data_d = in_wb_data;
        end else begin
          wb_we_d   = 1'b1;
          wb_rd_d   = AddrD_in;
          wb_data_d = in_wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_rd_q   <= '0;
      pend_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      pend_vld_q  <= pend_vld_d;
      pend_rd_q   <= pend_rd_d;
      pend_data_q <= pend_data_d;
      misalign_q  <= misalign_d;
    end
  end

  assign dmem_req     = (state_q == REQ);
  assign dmem_we      = dmem_req && cap_q.store;
  assign dmem_addr    = dmem_req ? {cap_q.addr[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata   = dmem_we ? lsu_wdata : '0;
  assign dmem_wstrb   = dmem_we ? lsu_wstrb : 4'd0;

  assign RegWEn_out   = wb_we_q;
  assign AddrD_out    = wb_rd_q;
  assign DataD_out    = wb_data_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed checks of mem_wb_stage: ALU/JAL writeback, loads and stores over the dmem handshake,
// misalignment drop, x0 guard, back-to-back load+ALU retirement and reset during an open access.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] alu_result_in, DataB_in, pcPlus4_in;
  logic [4:0]  AddrD_in;
  logic        RegWEn_in, MemRW_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        RegWEn_out;
  logic [4:0]  AddrD_out;
  logic [31:0] DataD_out;
  logic        misalign_err;

  int n_chk  = 0;
  int n_pass = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32), .WB_X0_GUARD(1'b1)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .DataB_in(DataB_in), .pcPlus4_in(pcPlus4_in), .AddrD_in(AddrD_in), .RegWEn_in(RegWEn_in),
    .MemRW_in(MemRW_in), .WBSel_in(WBSel_in), .funct3_in(funct3_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .RegWEn_out(RegWEn_out), .AddrD_out(AddrD_out),
    .DataD_out(DataD_out), .misalign_err(misalign_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [31:0] datab, input logic [31:0] pc4,
                      input logic [4:0] rd, input logic we, input logic mrw,
                      input logic [1:0] sel, input logic [2:0] f3);
    valid_in      = 1'b1;
    alu_result_in = alu;
    DataB_in      = datab;
    pcPlus4_in    = pc4;
    AddrD_in      = rd;
    RegWEn_in     = we;
    MemRW_in      = mrw;
    WBSel_in      = sel;
    funct3_in     = f3;
  endtask

  task automatic idle_in;
    valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    send(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b01, 3'b000);
    idle_in();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) step();

    chk("rst_regwen", {31'd0, RegWEn_out}, 32'd0);
    chk("rst_addrd", {27'd0, AddrD_out}, 32'd0);
    chk("rst_datad", DataD_out, 32'd0);
    chk("rst_req_stall", {30'd0, dmem_req, stall_out}, 32'd0);
    chk("rst_wstrb_mis", {27'd0, dmem_wstrb, misalign_err}, 32'd0);
    reset = 1'b0;

    // ADD x5 = 0x1234
    send(32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 2'b01, 3'b000);
    #1 chk("add_stall", {31'd0, stall_out}, 32'd0);
    step(); idle_in();
    chk("add_regwen", {31'd0, RegWEn_out}, 32'd1);
    chk("add_addrd", {27'd0, AddrD_out}, 32'd5);
    chk("add_datad", DataD_out, 32'h1234);
    step();
    chk("add_bubble", {31'd0, RegWEn_out}, 32'd0);
    chk("add_hold", DataD_out, 32'h1234);

    // LB x7, 0x103: ready on the 3rd REQ cycle, rvalid on the 2nd WAIT cycle -> 4 stalled cycles
    send(32'h103, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0, 2'b00, 3'b000);
    #1 chk("lb_idle_req", {31'd0, dmem_req}, 32'd0);
    step(); idle_in();
    stall_cnt = 0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD0000;
    #1;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_we", {31'd0, dmem_we}, 32'd0);
    stall_cnt += int'(stall_out);
    step();
    dmem_rvalid = 1'b0;
    chk("lb_rvalid_in_req_ignored", {31'd0, RegWEn_out}, 32'd0);
    #1 stall_cnt += int'(stall_out);
    step();
    dmem_ready = 1'b1;
    #1 stall_cnt += int'(stall_out);
    step();
    dmem_ready = 1'b0;
    #1 chk("lb_wait_no_req", {31'd0, dmem_req}, 32'd0);
    stall_cnt += int'(stall_out);
    step();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80AABBCC;
    #1 stall_cnt += int'(stall_out);
    step();
    dmem_rvalid = 1'b0;
    chk("lb_regwen", {31'd0, RegWEn_out}, 32'd1);
    chk("lb_addrd", {27'd0, AddrD_out}, 32'd7);
    chk("lb_datad", DataD_out, 32'hFFFFFF80);
    chk("lb_stall_cycles", stall_cnt, 32'd4);

    // SH 0x102 <- 0xDEADBEEF, ready immediately
    send(32'h102, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b1, 2'b01, 3'b001);
    step(); idle_in();
    dmem_ready = 1'b1;
    #1;
    chk("sh_req_we", {30'd0, dmem_req, dmem_we}, 32'd3);
    chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", dmem_addr, 32'h100);
    chk("sh_stall", {31'd0, stall_out}, 32'd0);
    step();
    dmem_ready = 1'b0;
    chk("sh_no_wb", {31'd0, RegWEn_out}, 32'd0);
    chk("sh_req_drop", {31'd0, dmem_req}, 32'd0);

    // SB 0x101 <- 0xA5
    send(32'h101, 32'h000000A5, 32'h0, 5'd0, 1'b0, 1'b1, 2'b01, 3'b000);
    step(); idle_in();
    dmem_ready = 1'b1;
    #1;
    chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    step();
    dmem_ready = 1'b0;

    // LW 0x101 is misaligned and must be dropped
    send(32'h101, 32'h0, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 3'b010);
    step(); idle_in();
    chk("lw_mis_err", {31'd0, misalign_err}, 32'd1);
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_regwen", {31'd0, RegWEn_out}, 32'd0);
    step();
    chk("lw_mis_pulse", {31'd0, misalign_err}, 32'd0);
    chk("lw_mis_req2", {31'd0, dmem_req}, 32'd0);

    // JAL x0 is suppressed, JAL x1 writes pc+4
    send(32'h0, 32'h0, 32'h40, 5'd0, 1'b1, 1'b0, 2'b10, 3'b000);
    step();
    chk("jal_x0_regwen", {31'd0, RegWEn_out}, 32'd0);
    chk("jal_x0_hold", DataD_out, 32'hFFFFFF80);
    send(32'h0, 32'h0, 32'h40, 5'd1, 1'b1, 1'b0, 2'b10, 3'b000);
    step(); idle_in();
    chk("jal_x1_regwen", {31'd0, RegWEn_out}, 32'd1);
    chk("jal_x1_addrd", {27'd0, AddrD_out}, 32'd1);
    chk("jal_x1_datad", DataD_out, 32'h40);

    // LW x3 retiring on the same edge an ADD x4 is accepted: both write back, load first
    send(32'h200, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0, 2'b00, 3'b010);
    step(); idle_in();
    dmem_ready = 1'b1;
    #1 chk("b2b_req", {31'd0, dmem_req}, 32'd1);
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    send(32'h55, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 2'b01, 3'b000);
    #1 chk("b2b_stall", {31'd0, stall_out}, 32'd0);
    step(); idle_in();
    dmem_rvalid = 1'b0;
    chk("b2b_ld_wb", {RegWEn_out, 26'd0, AddrD_out}, {1'b1, 26'd0, 5'd3});
    chk("b2b_ld_data", DataD_out, 32'h11223344);
    step();
    chk("b2b_add_wb", {RegWEn_out, 26'd0, AddrD_out}, {1'b1, 26'd0, 5'd4});
    chk("b2b_add_data", DataD_out, 32'h55);
    step();
    chk("b2b_bubble", {31'd0, RegWEn_out}, 32'd0);

    // Reset while waiting for read data; a late rvalid must not retire anything
    send(32'h202, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 3'b001);
    step(); idle_in();
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    #1 chk("rw_wait_stall", {31'd0, stall_out}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rw_req_stall", {30'd0, dmem_req, stall_out}, 32'd0);
    chk("rw_regwen", {31'd0, RegWEn_out}, 32'd0);
    step(); step();
    reset = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_rvalid = 1'b0;
    chk("rw_late_rvalid", {31'd0, RegWEn_out}, 32'd0);
    chk("rw_idle", {30'd0, dmem_req, stall_out}, 32'd0);
    send(32'h99, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 2'b01, 3'b000);
    step(); idle_in();
    chk("rw_add_wb", {RegWEn_out, 26'd0, AddrD_out}, {1'b1, 26'd0, 5'd2});
    chk("rw_add_data", DataD_out, 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
